// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and binary index; an owner keeps the grant until it drops req.
// Optional RR_ARB_TIMEOUT_EN: bounds each grant to MAX_HOLD cycles and pulses timeout on forced revocation.
module rr_onehot_arbiter #(
  parameter int NUM_REQ  = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  // Handshake: req[i] is a level held by requester i for as long as it wants the
  // resource; gnt[i] is the registered answer, and dropping req[i] ends the grant
  // on the next clock. No request is stored, so only levels present at a clock edge count.

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 timeout_q, timeout_d;

  logic                 any_req;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W:0]       cand;
  logic [NUM_REQ-1:0]   win_onehot;
  logic                 hold_ok;
  logic                 expire;
  logic                 grant_start;
  logic                 drop;
  logic [IDX_W-1:0]     ptr_after;

  assign any_req   = |req;
  assign hold_ok   = en && req[gnt_idx_q];
  assign ptr_after = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;

  // Search upward from ptr with wraparound; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= NUM_REQ_EXT) begin
        cand = cand - NUM_REQ_EXT;
      end
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  assign expire = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

  // Counts grant cycles already shown on gnt; zero on the first visible cycle.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (grant_start) begin
      hold_cnt_d = '0;
    end else if (state_q == GRANT) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      gnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_q       <= gnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_start = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && any_req && win_found) begin
          state_d     = GRANT;
          grant_start = 1'b1;
        end
      end
      GRANT: begin
        // Release and revocation both hand the lowest priority to the old owner.
        if (!hold_ok || expire) begin
          state_d = IDLE;
          ptr_d   = ptr_after;
          drop    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    gnt_d       = gnt_q;
    timeout_d   = 1'b0;
    if (grant_start) begin
      gnt_idx_d   = win_idx;
      gnt_valid_d = 1'b1;
      gnt_d       = win_onehot;
    end else if (drop) begin
      gnt_valid_d = 1'b0;
      gnt_d       = '0;
      timeout_d   = hold_ok && expire;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: vector table, rotation order, async reset and hold/timeout sequences.
module tb_rr_onehot_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        valid;
  } vec_t;

  vec_t vecs[22];

  rr_onehot_arbiter #(
    .NUM_REQ (16),
    .IDX_W   (4),
    .MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive inputs, let one rising edge sample them, then settle before checking.
  task automatic step(input logic e, input logic [15:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] eg, input logic [3:0] ei,
                       input logic ev, input logic et);
    checks++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || timeout !== et) begin
      failures++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
               name, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
    end
  endtask

  initial begin
    logic [3:0]  exp_idx;
    logic [15:0] one;
    one = 16'h0001;

    vecs[0]  = '{1'b1, 16'h0008, 16'h0008, 4'd3,  1'b1};
    vecs[1]  = '{1'b1, 16'h0008, 16'h0008, 4'd3,  1'b1};
    vecs[2]  = '{1'b1, 16'h0000, 16'h0000, 4'd3,  1'b0};
    vecs[3]  = '{1'b1, 16'h0011, 16'h0010, 4'd4,  1'b1};
    vecs[4]  = '{1'b1, 16'h0001, 16'h0000, 4'd4,  1'b0};
    vecs[5]  = '{1'b1, 16'h0011, 16'h0001, 4'd0,  1'b1};
    vecs[6]  = '{1'b1, 16'h0011, 16'h0001, 4'd0,  1'b1};
    vecs[7]  = '{1'b1, 16'h0010, 16'h0000, 4'd0,  1'b0};
    vecs[8]  = '{1'b1, 16'h0010, 16'h0010, 4'd4,  1'b1};
    vecs[9]  = '{1'b0, 16'h0010, 16'h0000, 4'd4,  1'b0};
    vecs[10] = '{1'b0, 16'h0010, 16'h0000, 4'd4,  1'b0};
    vecs[11] = '{1'b1, 16'h0080, 16'h0080, 4'd7,  1'b1};
    vecs[12] = '{1'b0, 16'h0080, 16'h0000, 4'd7,  1'b0};
    vecs[13] = '{1'b0, 16'h0080, 16'h0000, 4'd7,  1'b0};
    vecs[14] = '{1'b0, 16'h0080, 16'h0000, 4'd7,  1'b0};
    vecs[15] = '{1'b1, 16'h0000, 16'h0000, 4'd7,  1'b0};
    vecs[16] = '{1'b1, 16'h8000, 16'h8000, 4'd15, 1'b1};
    vecs[17] = '{1'b1, 16'h8001, 16'h8000, 4'd15, 1'b1};
    vecs[18] = '{1'b1, 16'h0001, 16'h0000, 4'd15, 1'b0};
    vecs[19] = '{1'b1, 16'h8001, 16'h0001, 4'd0,  1'b1};
    vecs[20] = '{1'b1, 16'h8000, 16'h0000, 4'd0,  1'b0};
    vecs[21] = '{1'b1, 16'h8001, 16'h8000, 4'd15, 1'b1};

    do_reset();
    #1;
    check("reset_idle", 16'h0000, 4'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].req);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].valid, 1'b0);
    end

    // Rotation: every bit requested; each owner drops its bit once after two grant cycles.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      exp_q.push_back(4'(k % 16));
    end
    for (int k = 0; k < 17; k++) begin
      exp_idx = exp_q.pop_front();
      step(1'b1, 16'hFFFF);
      check($sformatf("rot%0d_grant", k), one << exp_idx, exp_idx, 1'b1, 1'b0);
      step(1'b1, 16'hFFFF);
      check($sformatf("rot%0d_hold", k), one << exp_idx, exp_idx, 1'b1, 1'b0);
      step(1'b1, 16'hFFFF & ~(one << exp_idx));
      check($sformatf("rot%0d_dead", k), 16'h0000, exp_idx, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a grant to idx 5.
    do_reset();
    step(1'b1, 16'h0005);
    check("pre_rst_grant0", 16'h0001, 4'd0, 1'b1, 1'b0);
    step(1'b1, 16'h0020);
    step(1'b1, 16'h0020);
    check("pre_rst_grant5", 16'h0020, 4'd5, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst", 16'h0000, 4'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    step(1'b1, 16'h0020);
    check("post_rst_grant", 16'h0020, 4'd5, 1'b1, 1'b0);

    // Two contenders held continuously.
    do_reset();
`ifdef RR_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 16'h0003);
      check($sformatf("to_hold%0d", c), 16'h0001, 4'd0, 1'b1, 1'b0);
    end
    step(1'b1, 16'h0003);
    check("to_revoke", 16'h0000, 4'd0, 1'b0, 1'b1);
    step(1'b1, 16'h0003);
    check("to_next", 16'h0002, 4'd1, 1'b1, 1'b0);
`else
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 16'h0003);
      check($sformatf("nohold_limit%0d", c), 16'h0001, 4'd0, 1'b1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
